gtx_align_insert: RTL



---
 rtl/gtx_sata_prims_pkg.sv | 12 +
 rtl/gtx_align_insert.sv | 93 +++++++++
 2 files changed

// File: rtl/gtx_sata_prims_pkg.sv
// gtx_sata_prims_pkg: SATA primitive word/K constants and the align-insert FSM states, shared by TX and RX.
package gtx_sata_prims_pkg;
  typedef enum logic [1:0] {ALIGN, DATA_LO, DATA_HI, FILL_HI} state_t;
  localparam logic [15:0] ALIGNP_LO = 16'h4ABC;
  localparam logic [15:0] ALIGNP_HI = 16'h7B4A;
  localparam logic [15:0] SYNCP_LO = 16'h957C;
  localparam logic [15:0] SYNCP_HI = 16'hB5B5;
  localparam logic [1:0] ALIGNP_LO_K = 2'b01;
  localparam logic [1:0] ALIGNP_HI_K = 2'b00;
  localparam logic [1:0] SYNCP_LO_K = 2'b01;
  localparam logic [1:0] SYNCP_HI_K = 2'b00;
endpackage

// File: rtl/gtx_align_insert.sv
// gtx_align_insert: inserts ALIGNp bursts every ALIGN_PERIOD dwords and SYNCp fill ahead of the 8b/10b encoder.
// Define GTX_ALIGN_STATS_EN to add saturating align_bursts/underruns counters.
module gtx_align_insert
  import gtx_sata_prims_pkg::*;
#(
  parameter int ALIGN_PERIOD = 256,
  parameter int CNT_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] in_data,
  input  logic [1:0]  in_isk,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] out_data,
  output logic [1:0]  out_isk,
  output logic        underrun
`ifdef GTX_ALIGN_STATS_EN
  ,
  output logic [15:0] align_bursts,
  output logic [15:0] underruns
`endif
);
  state_t r_state, w_state;
  logic [1:0] r_idx, w_idx;
  logic [CNT_W-1:0] r_cnt, w_cnt;
  logic [15:0] w_data;
  logic [1:0] w_isk;
  logic w_und, w_wrap;
  assign w_wrap = r_cnt == CNT_W'(ALIGN_PERIOD - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ALIGN;
      r_idx <= '0;
      r_cnt <= '0;
    end else begin
      r_state <= w_state;
      r_idx <= w_idx;
      r_cnt <= w_cnt;
    end
  end
  // DATA_HI and FILL_HI both close a dword, so both advance the period counter.
  always_comb begin
    w_state = r_state;
    w_idx = '0;
    w_cnt = r_cnt;
    case (r_state)
      ALIGN: begin
        w_idx = r_idx + 2'd1;
        w_cnt = '0;
        w_state = r_idx == 2'd3 ? DATA_LO : ALIGN;
      end
      DATA_LO: w_state = in_valid ? DATA_HI : FILL_HI;
      default: begin
        w_state = w_wrap ? ALIGN : DATA_LO;
        w_cnt = w_wrap ? '0 : r_cnt + CNT_W'(1);
      end
    endcase
  end
  always_comb begin
    in_ready = !rst && (r_state == DATA_LO || r_state == DATA_HI);
    w_und = r_state == DATA_HI && !in_valid;
    {w_data, w_isk} = {SYNCP_HI, SYNCP_HI_K};
    case (r_state)
      ALIGN: {w_data, w_isk} = r_idx[0] ? {ALIGNP_HI, ALIGNP_HI_K} : {ALIGNP_LO, ALIGNP_LO_K};
      DATA_LO: {w_data, w_isk} = in_valid ? {in_data, in_isk} : {SYNCP_LO, SYNCP_LO_K};
      DATA_HI: {w_data, w_isk} = in_valid ? {in_data, in_isk} : {SYNCP_HI, SYNCP_HI_K};
      default: {w_data, w_isk} = {SYNCP_HI, SYNCP_HI_K};
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data <= '0;
      out_isk <= '0;
      underrun <= 1'b0;
    end else begin
      out_data <= w_data;
      out_isk <= w_isk;
      underrun <= w_und;
    end
  end
`ifdef GTX_ALIGN_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      align_bursts <= '0;
      underruns <= '0;
    end else begin
      if (r_state == ALIGN && r_idx == 2'd3 && align_bursts != 16'hFFFF) align_bursts <= align_bursts + 16'd1;
      if (w_und && underruns != 16'hFFFF) underruns <= underruns + 16'd1;
    end
  end
`endif
endmodule
